// File: rtl/reg_snapshot_receiver.sv
// reg_snapshot_receiver: rebuilds the DEPTH x WIDTH register snapshot from the serial frame and commits it atomically at frame end.
// Optional SNAP_CHANGE_DETECT_EN adds a per-word changed_mask computed at each commit.
module reg_snapshot_receiver #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             start_in,
  input  logic [3:0]       rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             frame_valid,
  output logic             have_frame,
  output logic             frame_err,
  output logic [7:0]       frame_count,
  output logic [7:0]       err_count,
  output logic [DEPTH-1:0] changed_mask
);
  localparam int N  = WIDTH * DEPTH;
  localparam int CW = $clog2(N);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [N-1:0]     r_shift;
  logic [N-1:0]     r_shadow;
  logic [N-1:0]     w_next;
  logic             w_commit;
  logic [WIDTH-1:0] w_words [16];
  assign w_next   = {serial_in, r_shift[N-1:1]};
  assign w_commit = (r_state == SHIFT) && !start_in && (r_cnt == CW'(N - 1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_shadow    <= '0;
      busy        <= 1'b0;
      frame_valid <= 1'b0;
      have_frame  <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (r_state == IDLE) begin
        if (start_in) begin
          r_shift <= w_next;
          r_cnt   <= CW'(1);
          r_state <= SHIFT;
          busy    <= 1'b1;
        end
      end else begin
        r_shift <= w_next;
        if (start_in) begin
          r_cnt     <= CW'(1);
          frame_err <= 1'b1;
          err_count <= err_count + {7'd0, err_count != 8'hFF};
        end else if (w_commit) begin
          r_shadow    <= w_next;
          frame_valid <= 1'b1;
          have_frame  <= 1'b1;
          frame_count <= frame_count + 8'd1;
          r_cnt       <= '0;
          r_state     <= IDLE;
          busy        <= 1'b0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end
  // rd_idx spans 16 slots; those past DEPTH read as zero
  for (genvar g = 0; g < 16; g++) begin : g_rd
    if (g < DEPTH) begin : g_word
      assign w_words[g] = r_shadow[g*WIDTH +: WIDTH];
    end else begin : g_zero
      assign w_words[g] = '0;
    end
  end
  assign rd_data = w_words[rd_idx];
`ifdef SNAP_CHANGE_DETECT_EN
  logic [DEPTH-1:0] w_diff;
  always_comb begin
    w_diff = '0;
    for (int i = 0; i < DEPTH; i++) w_diff[i] = w_next[i*WIDTH +: WIDTH] != r_shadow[i*WIDTH +: WIDTH];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) changed_mask <= '0;
    else if (w_commit) changed_mask <= w_diff;
  end
`else
  assign changed_mask = '0;
`endif
endmodule

// File: tb/tb_reg_snapshot_receiver.sv
// tb_reg_snapshot_receiver: random frames, aborts and resets checked against a word-level model of the snapshot receiver.
module tb_reg_snapshot_receiver;
  localparam int W = 8;
  localparam int D = 12;
  localparam int N = W * D;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         serial_in = 1'b0;
  logic         start_in = 1'b0;
  logic [3:0]   rd_idx = 4'd0;
  logic [W-1:0] rd_data;
  logic         busy, frame_valid, have_frame, frame_err;
  logic [7:0]   frame_count, err_count;
  logic [D-1:0] changed_mask;
  int           n_checks = 0;
  int           n_fail = 0;
  logic [W-1:0] m_sh [D];
  int           m_fc, m_ec;
  bit           m_have, m_busy;
  logic [D-1:0] m_mask;
  logic [N-1:0] f;

  reg_snapshot_receiver #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .start_in(start_in), .rd_idx(rd_idx),
    .rd_data(rd_data), .busy(busy), .frame_valid(frame_valid), .have_frame(have_frame),
    .frame_err(frame_err), .frame_count(frame_count), .err_count(err_count),
    .changed_mask(changed_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_mask();
`ifdef SNAP_CHANGE_DETECT_EN
    return 32'(m_mask);
`else
    return 32'd0;
`endif
  endfunction

  task automatic step(input logic s, input logic d);
    start_in  = s;
    serial_in = d;
    @(negedge clk);
  endtask

  task automatic chk_rd(input int i);
    rd_idx = 4'(i);
    #1;
    check("rd_data", 32'(rd_data), i < D ? 32'(m_sh[i]) : 32'd0);
  endtask

  task automatic model_reset();
    foreach (m_sh[i]) m_sh[i] = '0;
    m_fc = 0; m_ec = 0; m_have = 0; m_busy = 0; m_mask = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(frame_valid), 32'd0);
    check("rst_have", 32'(have_frame), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_fc", 32'(frame_count), 32'd0);
    check("rst_ec", 32'(err_count), 32'd0);
    check("rst_mask", 32'(changed_mask), 32'd0);
    chk_rd(0);
    chk_rd($urandom_range(1, D - 1));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // A start bit aborts whatever frame is in flight.
  task automatic start_bit(input logic d);
    bit ab = m_busy;
    step(1'b1, d);
    if (ab) m_ec = m_ec < 255 ? m_ec + 1 : 255;
    m_busy = 1;
    check("frame_err", 32'(frame_err), 32'(ab));
    check("err_count", 32'(err_count), 32'(m_ec));
    check("busy_start", 32'(busy), 32'd1);
    check("valid_pulse", 32'(frame_valid), 32'd0);
  endtask

  task automatic send(input logic [N-1:0] fr, input int ab);
    if (ab > 0) begin
      start_bit(1'($urandom));
      for (int k = 1; k < ab; k++) step(1'b0, 1'($urandom));
    end
    start_bit(fr[0]);
    if (ab > 0) chk_rd($urandom_range(0, D - 1));
    for (int k = 1; k < N; k++) begin
      if (k == N - 1) check("early_valid", 32'(frame_valid), 32'd0);
      step(1'b0, fr[k]);
    end
    for (int i = 0; i < D; i++) begin
      m_mask[i] = fr[i*W +: W] != m_sh[i];
      m_sh[i]   = fr[i*W +: W];
    end
    m_fc = (m_fc + 1) % 256; m_have = 1; m_busy = 0;
    check("frame_valid", 32'(frame_valid), 32'd1);
    check("busy_end", 32'(busy), 32'd0);
    check("have_frame", 32'(have_frame), 32'(m_have));
    check("frame_count", 32'(frame_count), 32'(m_fc));
    check("err_count_end", 32'(err_count), 32'(m_ec));
    check("changed_mask", 32'(changed_mask), exp_mask());
    chk_rd($urandom_range(0, 15));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'($urandom));
    if (n > 0) begin
      check("idle_valid", 32'(frame_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    for (int i = 0; i < D; i++) f[i*W +: W] = 8'h10 + 8'(i);
    send(f, 0);
    rd_idx = 4'd5; #1;
    check("t1_word5", 32'(rd_data), 32'h15);
    check("t1_fc", 32'(frame_count), 32'd1);
    f = {$urandom, $urandom, $urandom};
    send(f, 0);
    rd_idx = 4'd0; #1;
    check("t2_word0", 32'(rd_data), 32'(f[W-1:0]));
    check("t2_fc", 32'(frame_count), 32'd2);
    idle(2);
    send({$urandom, $urandom, $urandom}, 40);
    check("t3_ec", 32'(err_count), 32'd1);
    idle(1);
    f = {$urandom, $urandom, $urandom};
    f[3*W +: W] = 8'h33;
    send(f, 0);
    f[3*W +: W] = 8'hFF;
    send(f, 0);
`ifdef SNAP_CHANGE_DETECT_EN
    check("t5_mask", 32'(changed_mask), 32'h008);
`else
    check("t5_mask", 32'(changed_mask), 32'h000);
`endif
    chk_rd(12);
    chk_rd(15);
    start_bit(1'($urandom));
    for (int k = 1; k < 50; k++) step(1'b0, 1'($urandom));
    do_reset();
    repeat (40) begin
      send({$urandom, $urandom, $urandom}, ($urandom % 4 == 0) ? $urandom_range(1, N - 1) : 0);
      idle($urandom_range(0, 3));
    end
    do_reset();
    repeat (300) send({$urandom, $urandom, $urandom}, 0);
    check("t6_fc_wrap", 32'(frame_count), 32'd44);
    start_bit(1'($urandom));
    repeat (260) start_bit(1'($urandom));
    check("t6_ec_sat", 32'(err_count), 32'd255);
    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
